top_test_uart: RTL and testbench



---
 rtl/top_test_uart_pkg.sv | 8 +
 rtl/top_test_uart_rx.sv | 77 +++++++
 rtl/top_test_uart.sv | 48 ++++
 tb/tb_top_test_uart.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/top_test_uart_pkg.sv
// top_test_uart_pkg: shared 8N1 frame constants and receiver state encoding
package top_test_uart_pkg;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/top_test_uart_rx.sv
// uart_rx: 2-flop synchronizer and 16x-oversampled 8N1 receiver; UART_STOP_CHECK_EN drops frames with a bad stop bit
module uart_rx
  import top_test_uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable2,
  input  logic                  rx,
  output logic                  ff1_out,
  output logic                  ff2_out,
  output logic [DATA_BITS-1:0]  dout_byte,
  output logic                  dout_byte_rdy,
  output logic [FRAME_BITS-1:0] dout_byte_temp
);
  rx_state_e             state;
  logic [3:0]            tick_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shifted;
  logic                  stop_ok;
  always_comb shifted = {ff2_out, dout_byte_temp[FRAME_BITS-1:1]};
`ifdef UART_STOP_CHECK_EN
  always_comb stop_ok = ff2_out;
`else
  always_comb stop_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ff1_out <= 1'b1;
      ff2_out <= 1'b1;
    end else begin
      ff1_out <= rx;
      ff2_out <= ff1_out;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      dout_byte      <= '0;
      dout_byte_rdy  <= 1'b0;
      dout_byte_temp <= '0;
    end else begin
      dout_byte_rdy <= 1'b0;
      if (enable2)
        case (state)
          IDLE:
            if (!ff2_out) begin
              state    <= START;
              tick_cnt <= '0;
            end
          START:
            if (tick_cnt == 4'(MID_SAMPLE - 1)) begin
              state    <= ff2_out ? IDLE : DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!ff2_out) dout_byte_temp <= shifted;
            end else tick_cnt <= tick_cnt + 4'd1;
          DATA:
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt       <= '0;
              bit_cnt        <= bit_cnt + 4'd1;
              dout_byte_temp <= shifted;
              if (bit_cnt == 4'(DATA_BITS - 1)) state <= STOP;
            end else tick_cnt <= tick_cnt + 4'd1;
          STOP:
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              state          <= IDLE;
              tick_cnt       <= '0;
              dout_byte_temp <= shifted;
              if (stop_ok) begin
                dout_byte     <= shifted[DATA_BITS:1];
                dout_byte_rdy <= 1'b1;
              end
            end else tick_cnt <= tick_cnt + 4'd1;
        endcase
    end
endmodule

// File: rtl/top_test_uart.sv
// top_test_uart: 8N1 transmitter looped back into uart_rx; UART_STOP_CHECK_EN enables stop-bit framing checks
module top_test_uart
  import top_test_uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable1,
  input  logic                  enable2,
  input  logic                  din_rdy,
  input  logic [DATA_BITS-1:0]  din_byte,
  output logic [DATA_BITS-1:0]  dout_byte,
  output logic                  ser_out,
  output logic                  dout_byte_rdy,
  output logic                  uart_ready,
  output logic                  ff1_out,
  output logic                  ff2_out,
  output logic [3:0]            shift_count,
  output logic [DATA_BITS:0]    data_buf,
  output logic [FRAME_BITS-1:0] dout_byte_temp
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ser_out     <= 1'b1;
      uart_ready  <= 1'b1;
      shift_count <= '0;
      data_buf    <= '1;
    end else if (din_rdy && uart_ready) begin
      data_buf    <= {din_byte, 1'b0};
      shift_count <= '0;
      uart_ready  <= 1'b0;
    end else if (enable1 && !uart_ready) begin
      ser_out     <= data_buf[0];
      data_buf    <= {1'b1, data_buf[DATA_BITS:1]};
      shift_count <= shift_count + 4'd1;
      uart_ready  <= shift_count == 4'(FRAME_BITS - 1);
    end
  uart_rx u_rx (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable2        (enable2),
    .rx             (ser_out),
    .ff1_out        (ff1_out),
    .ff2_out        (ff2_out),
    .dout_byte      (dout_byte),
    .dout_byte_rdy  (dout_byte_rdy),
    .dout_byte_temp (dout_byte_temp)
  );
endmodule

// File: tb/tb_top_test_uart.sv
// tb_top_test_uart: table-driven loopback checks with a byte scoreboard; UART_STOP_CHECK_EN adds the framing-error case
module tb_top_test_uart;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable1 = 1'b0;
  logic       enable2 = 1'b0;
  logic       din_rdy = 1'b0;
  logic [7:0] din_byte = 8'h00;
  logic [7:0] dout_byte;
  logic       ser_out;
  logic       dout_byte_rdy;
  logic       uart_ready;
  logic       ff1_out;
  logic       ff2_out;
  logic [3:0] shift_count;
  logic [8:0] data_buf;
  logic [9:0] dout_byte_temp;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int p2 = 128;
  int div = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;
  } vec_t;
  vec_t tbl[6];

  top_test_uart dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable1        (enable1),
    .enable2        (enable2),
    .din_rdy        (din_rdy),
    .din_byte       (din_byte),
    .dout_byte      (dout_byte),
    .ser_out        (ser_out),
    .dout_byte_rdy  (dout_byte_rdy),
    .uart_ready     (uart_ready),
    .ff1_out        (ff1_out),
    .ff2_out        (ff2_out),
    .shift_count    (shift_count),
    .data_buf       (data_buf),
    .dout_byte_temp (dout_byte_temp)
  );

  always #5 clk = ~clk;

  // enable2 every p2 clocks, enable1 on every 16th enable2
  always @(negedge clk) begin
    div = div + 1;
    enable2 = (div % p2) == 0;
    enable1 = (div % (16 * p2)) == 0;
  end

  always @(negedge clk)
    if (dout_byte_rdy) begin
      rx_cnt = rx_cnt + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rx_unexpected: got dout_byte=%h, required no delivery", dout_byte);
      end else begin
        exp_b = sb.pop_front();
        if (dout_byte !== exp_b) begin
          errors = errors + 1;
          $display("FAIL rx_byte: got %h required %h", dout_byte, exp_b);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!enable1 && n < 5000);
    if (!enable1) chk("tick_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 32 * p2) begin
      @(negedge clk);
      n++;
    end
    chk("rx_arrival", rx_cnt, target);
  endtask

  task automatic frame(input logic [7:0] b, input logic [9:0] f, input bit push,
                       input int inj_tick, input int rst_tick, input bit force_stop);
    int n = 0;
    logic [8:0] ld;
    logic [8:0] exp_db;
    while (!uart_ready && n < 40000) begin
      @(negedge clk);
      n++;
    end
    din_rdy = 1'b1;
    din_byte = b;
    if (push) sb.push_back(b);
    @(negedge clk);
    din_rdy = 1'b0;
    ld = {b, 1'b0};
    chk("load_ready", uart_ready, 0);
    chk("load_buf", data_buf, ld);
    for (int t = 1; t <= 10; t++) begin
      wait_tick();
      chk("ser_bit", ser_out, f[t-1]);
      if (t == rst_tick) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ser", ser_out, 1);
        chk("rst_ready", uart_ready, 1);
        chk("rst_count", shift_count, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (t == inj_tick) begin
        exp_db = (ld >> t) | ~(9'h1FF >> t);
        din_rdy = 1'b1;
        din_byte = 8'hC3;
        @(negedge clk);
        din_rdy = 1'b0;
        chk("busy_ready", uart_ready, 0);
        chk("busy_buf", data_buf, exp_db);
      end
      if (t == 9) chk("ready_t9", uart_ready, 0);
      if (t == 10) begin
        chk("ready_t10", uart_ready, 1);
        chk("count_t10", shift_count, 10);
`ifdef UART_STOP_CHECK_EN
        if (force_stop) begin
          force dut.u_rx.ff1_out = 1'b0;
          repeat (12 * p2) @(negedge clk);
          release dut.u_rx.ff1_out;
        end
`endif
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'h00, 10'h200};
    tbl[1] = '{8'h01, 10'h202};
    tbl[2] = '{8'h02, 10'h204};
    tbl[3] = '{8'h03, 10'h206};
    tbl[4] = '{8'h5A, 10'h2B4};
    tbl[5] = '{8'hFF, 10'h3FE};
    #6;
    chk("rst_ser_out", ser_out, 1);
    chk("rst_uart_ready", uart_ready, 1);
    chk("rst_dout_byte", dout_byte, 0);
    chk("rst_dout_rdy", dout_byte_rdy, 0);
    chk("rst_data_buf", data_buf, 9'h1FF);
    chk("rst_shift_count", shift_count, 0);
    chk("rst_ff1", ff1_out, 1);
    chk("rst_ff2", ff2_out, 1);
    chk("rst_temp", dout_byte_temp, 0);
    #4 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    frame(8'hAA, 10'h354, 1, 0, 0, 0);
    wait_rx(1);
    chk("aa_dout", dout_byte, 8'hAA);
    chk("aa_temp", dout_byte_temp, 10'h354);
    repeat (20) @(negedge clk);
    chk("aa_single_pulse", rx_cnt, 1);

    p2 = 4;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 6; i++) frame(tbl[i].din, tbl[i].frame, 1, 0, 0, 0);
    wait_rx(7);
    chk("stream_temp", dout_byte_temp, tbl[5].frame);
    chk("stream_dout", dout_byte, tbl[5].din);

    frame(8'h3C, 10'h278, 1, 4, 0, 0);
    wait_rx(8);
    repeat (40 * p2) @(negedge clk);
    chk("busy_no_extra", rx_cnt, 8);
    chk("busy_idle", uart_ready, 1);
    chk("busy_dout", dout_byte, 8'h3C);

    frame(8'h81, 10'h302, 0, 0, 5, 0);
    repeat (40 * p2) @(negedge clk);
    chk("rst_no_rx", rx_cnt, 8);
    chk("rst_dout_clr", dout_byte, 0);
    frame(8'h96, 10'h32C, 1, 0, 0, 0);
    wait_rx(9);
    chk("recover_temp", dout_byte_temp, 10'h32C);

`ifdef UART_STOP_CHECK_EN
    frame(8'hE7, 10'h3CE, 0, 0, 0, 1);
    repeat (40 * p2) @(negedge clk);
    chk("frm_err_no_rx", rx_cnt, 9);
    chk("frm_err_dout", dout_byte, 8'h96);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
